arm_mc_controller: RTL and testbench
====================================

ARM_MC_CONTROLLER -- requirements
Module: arm_mc_controller

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0, meaning 1 = FETCH/MEMREAD/MEMWRITE stall until MemReady, 0 = single-cycle memory with MemReady ignored.
REQ-002 SHALL have parameter SHIFT_EN, default 1, meaning 1 = MOV-class command (cmd 1101) decodes to shift operation, 0 = MOV decodes to ALU pass-B.
REQ-003 SHALL have ports, in order: clk in 1 clock; reset in 1 asynchronous active-low reset; Instr in 20 instruction bits [31:12] (Cond, Op, Funct, Rd); ALUFlags in 4 NZCV from ALU; MemReady in 1 memory done.
REQ-004 SHALL have output ports: PCWrite 1; MemWrite 1; RegWrite 1; IRWrite 1; AdrSrc 1; RegSrc 2; ALUSrcA 2; ALUSrcB 2; ResultSrc 2; ImmSrc 2; ALUControl 3; Shift 1; State 4 (debug).

Function
REQ-005 SHALL implement Moore FSM encoded FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9; State SHALL equal current encoding.
REQ-006 Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR (Op=01), EXECUTER (Op=00, Funct[5]=0), EXECUTEI (Op=00, Funct[5]=1), BRANCH (Op=10), FETCH (Op=11); MEMADR->MEMREAD (Funct[0]=1) else MEMWRITE; MEMREAD->MEMWB; EXECUTER/EXECUTEI->ALUWB; MEMWB, MEMWRITE, ALUWB, BRANCH->FETCH.
REQ-007 With MEM_WAIT=1, FETCH, MEMREAD and MEMWRITE SHALL hold state while MemReady=0 and advance in the cycle MemReady=1.
REQ-008 FETCH SHALL drive AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=ADD; IRWrite and PCWrite SHALL be 1, with MEM_WAIT=1 only when MemReady=1.
REQ-009 DECODE SHALL drive ALUSrcA=01, ALUSrcB=10, ResultSrc=10 (R15 reads PC+8); MEMADR ALUSrcA=00, ALUSrcB=01, ALUControl=ADD; MEMREAD AdrSrc=1; MEMWB ResultSrc=01, RegWrite; MEMWRITE AdrSrc=1, MemWrite; EXECUTER ALUSrcB=00; EXECUTEI ALUSrcB=01; ALUWB ResultSrc=00, RegWrite; BRANCH ALUSrcA=00, ALUSrcB=01, ResultSrc=10, PCWrite.
REQ-010 ALUControl in EXECUTE states SHALL decode Funct[4:1]: 0100 ADD=000, 0010 SUB=001, 0000 AND=010, 1100 ORR=011, 0001 EOR=100, 1010 CMP=001 with NoWrite, 1101 MOV=101 with Shift=SHIFT_EN; other cmd SHALL yield ADD.
REQ-011 ImmSrc SHALL equal Op; RegSrc[0]=1 when Op=10, RegSrc[1]=1 when Op=01; both combinational from Instr in all states.
REQ-012 Condition SHALL be evaluated in DECODE from Cond and flags register (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL; 1111 = false) and latched into CondExR at DECODE exit.
REQ-013 RegWrite, MemWrite and non-FETCH PCWrite SHALL be gated by CondExR; NoWrite SHALL suppress RegWrite in ALUWB.
REQ-014 ALUWB or MEMWB with Rd=1111 SHALL assert PCWrite (gated by CondExR) and not RegWrite.
REQ-015 Flags register SHALL load at EXECUTE exit when Funct[0]=1 and condition true: NZ always, CV only for ADD/SUB/CMP.
REQ-016 MEMWRITE with CondExR=0 SHALL drive MemWrite=0 and go to FETCH without waiting for MemReady.

Reset
REQ-017 reset=0 SHALL asynchronously force State=FETCH, flags register=0000, CondExR=0.
REQ-018 During reset all enables (PCWrite, MemWrite, RegWrite, IRWrite) SHALL be 0; other outputs SHALL take FETCH values.
REQ-019 reset asserted mid-instruction, including during a MEM_WAIT stall, SHALL abandon it; first cycle after release SHALL be FETCH.

Verification
REQ-020 ADD R1,R2,R3 (Instr[31:12]=0xE0821), MEM_WAIT=0 -> states 0,1,6,8,0; ALUWB RegWrite=1, ALUControl=000.
REQ-021 SUBS with result flags 0100 then ADDEQ -> second instruction reaches ALUWB with RegWrite=1; same ADDNE -> RegWrite=0.
REQ-022 LDR, MEM_WAIT=1, MemReady low 3 cycles in MEMREAD -> State stays 3 for 3 cycles, then 4 with RegWrite=1.
REQ-023 STRNE with Z=1 -> MEMWRITE lasts 1 cycle, MemWrite=0, next State=0.
REQ-024 CMP R1,R2 -> ALUControl=001, flags updated, RegWrite=0 in ALUWB; B -> State 9 with PCWrite=1.
REQ-025 reset dropped in MEMREAD stall -> State=0 immediately, all enables 0, flags=0000.

Source files
------------

// File: rtl/arm_mc_controller.sv
// Multicycle ARM controller: Moore main FSM, ALU command decode,
// condition check against a latched NZCV flags register, and optional
// memory wait handshaking for FETCH/MEMREAD/MEMWRITE.
module arm_mc_controller #(
    parameter int MEM_WAIT = 0,
    parameter int SHIFT_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        Shift,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t      state;
    state_t      next;
    logic [3:0]  flags;
    logic        condexr;
    logic        cond_true;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        rd15;
    logic        ready;
    logic        unused_rn;

    logic [2:0]  alu_dec;
    logic        shift_dec;
    logic        nowrite;
    logic        cv_upd;

    logic        pcw;
    logic        memw;
    logic        regw;
    logic        irw;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];
    assign rd15      = (rd == 4'hF);
    assign ready     = (MEM_WAIT == 0) || MemReady;

    assign ImmSrc    = op;
    assign RegSrc    = {op == 2'b01, op == 2'b10};
    assign State     = state;

    // Enables are forced low while reset is held; the rest already shows FETCH.
    assign PCWrite   = pcw  & reset;
    assign MemWrite  = memw & reset;
    assign RegWrite  = regw & reset;
    assign IRWrite   = irw  & reset;

    // Condition code evaluation against the stored NZCV flags.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'b0000: cond_true = flags[2];
            4'b0001: cond_true = ~flags[2];
            4'b0010: cond_true = flags[1];
            4'b0011: cond_true = ~flags[1];
            4'b0100: cond_true = flags[3];
            4'b0101: cond_true = ~flags[3];
            4'b0110: cond_true = flags[0];
            4'b0111: cond_true = ~flags[0];
            4'b1000: cond_true = flags[1] & ~flags[2];
            4'b1001: cond_true = ~flags[1] | flags[2];
            4'b1010: cond_true = (flags[3] == flags[0]);
            4'b1011: cond_true = (flags[3] != flags[0]);
            4'b1100: cond_true = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: cond_true = flags[2] | (flags[3] != flags[0]);
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // Data-processing command decode from Funct[4:1].
    always_comb begin
        alu_dec   = 3'b000;
        shift_dec = 1'b0;
        nowrite   = 1'b0;
        cv_upd    = 1'b0;
        case (funct[4:1])
            4'b0100: cv_upd = 1'b1;
            4'b0010: begin alu_dec = 3'b001; cv_upd = 1'b1; end
            4'b0000: alu_dec = 3'b010;
            4'b1100: alu_dec = 3'b011;
            4'b0001: alu_dec = 3'b100;
            4'b1010: begin alu_dec = 3'b001; nowrite = 1'b1; cv_upd = 1'b1; end
            4'b1101: begin alu_dec = 3'b101; shift_dec = (SHIFT_EN != 0); end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= next;
    end

    // Condition latch at DECODE exit and flag updates at EXECUTE exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags   <= '0;
            condexr <= 1'b0;
        end else begin
            if (state == DECODE) condexr <= cond_true;
            if ((state == EXECUTER || state == EXECUTEI) && funct[0] && condexr) begin
                flags[3:2] <= ALUFlags[3:2];
                if (cv_upd) flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        next       = state;
        pcw        = 1'b0;
        memw       = 1'b0;
        regw       = 1'b0;
        irw        = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 3'b000;
        Shift      = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irw       = ready;
                pcw       = ready;
                if (ready) next = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b00:   next = funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   next = MEMADR;
                    2'b10:   next = BRANCH;
                    default: next = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                next    = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (ready) next = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                regw      = condexr & ~rd15;
                pcw       = condexr & rd15;
                next      = FETCH;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                memw   = condexr;
                if (ready || !condexr) next = FETCH;
            end
            EXECUTER, EXECUTEI: begin
                ALUSrcB    = (state == EXECUTEI) ? 2'b01 : 2'b00;
                ALUControl = alu_dec;
                Shift      = shift_dec;
                next       = ALUWB;
            end
            ALUWB: begin
                regw = condexr & ~nowrite & ~rd15;
                pcw  = condexr & rd15;
                next = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pcw       = condexr;
                next      = FETCH;
            end
            default: next = FETCH;
        endcase
    end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Bench for arm_mc_controller: two instances (single-cycle memory with
// shifter, wait-state memory without shifter) exercised in turn against a
// path-per-instruction reference model.
module tb_arm_mc_controller;

    logic        clk = 1'b0;
    logic        rst0 = 1'b0;
    logic        rst1 = 1'b0;
    logic [19:0] instr = '0;
    logic [3:0]  aluflags = '0;
    logic        memready = 1'b0;
    int          sel = 0;

    int checks = 0;
    int failures = 0;

    logic [3:0] m_flags = '0;
    bit         m_cond = 1'b0;

    logic        pcw0, mw0, rw0, irw0, adr0, sh0;
    logic [1:0]  rs0, sa0, sb0, res0, imm0;
    logic [2:0]  alu0;
    logic [3:0]  st0;
    logic        pcw1, mw1, rw1, irw1, adr1, sh1;
    logic [1:0]  rs1, sa1, sb1, res1, imm1;
    logic [2:0]  alu1;
    logic [3:0]  st1;
    logic [22:0] obs0, obs1, obs;

    always #5 clk = ~clk;

    arm_mc_controller #(.MEM_WAIT(0), .SHIFT_EN(1)) dut0 (
        .clk(clk), .reset(rst0), .Instr(instr), .ALUFlags(aluflags), .MemReady(memready),
        .PCWrite(pcw0), .MemWrite(mw0), .RegWrite(rw0), .IRWrite(irw0), .AdrSrc(adr0),
        .RegSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ResultSrc(res0), .ImmSrc(imm0),
        .ALUControl(alu0), .Shift(sh0), .State(st0)
    );

    arm_mc_controller #(.MEM_WAIT(1), .SHIFT_EN(0)) dut1 (
        .clk(clk), .reset(rst1), .Instr(instr), .ALUFlags(aluflags), .MemReady(memready),
        .PCWrite(pcw1), .MemWrite(mw1), .RegWrite(rw1), .IRWrite(irw1), .AdrSrc(adr1),
        .RegSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ResultSrc(res1), .ImmSrc(imm1),
        .ALUControl(alu1), .Shift(sh1), .State(st1)
    );

    assign obs0 = {pcw0, mw0, rw0, irw0, adr0, rs0, sa0, sb0, res0, imm0, alu0, sh0, st0};
    assign obs1 = {pcw1, mw1, rw1, irw1, adr1, rs1, sa1, sb1, res1, imm1, alu1, sh1, st1};
    assign obs  = (sel == 1) ? obs1 : obs0;

    function automatic bit cond_holds(logic [3:0] cc, logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 3'b001;
            4'b0000: return 3'b010;
            4'b1100: return 3'b011;
            4'b0001: return 3'b100;
            4'b1101: return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    // Expected output vector for a given step of the instruction's path.
    function automatic logic [22:0] expv(logic [3:0] p, logic [19:0] ins, bit mr, bit c,
                                         bit mw, bit se);
        logic pcw, mwr, rw, irw, adr, sh;
        logic [1:0] a, b, r, op;
        logic [2:0] alu;
        logic [3:0] cmd;
        bit rd15;
        op = ins[15:14]; cmd = ins[12:9]; rd15 = (ins[3:0] == 4'hF);
        pcw = 0; mwr = 0; rw = 0; irw = 0; adr = 0; sh = 0;
        a = 0; b = 0; r = 0; alu = 0;
        case (p)
            4'd0: begin a = 1; b = 2; r = 2; irw = mw ? mr : 1'b1; pcw = irw; end
            4'd1: begin a = 1; b = 2; r = 2; end
            4'd2: b = 1;
            4'd3: adr = 1;
            4'd4: begin r = 1; rw = c && !rd15; pcw = c && rd15; end
            4'd5: begin adr = 1; mwr = c; end
            4'd6, 4'd7: begin
                b = (p == 4'd7) ? 2'd1 : 2'd0;
                alu = alu_of(cmd);
                sh = (cmd == 4'b1101) && se;
            end
            4'd8: begin rw = c && (cmd != 4'b1010) && !rd15; pcw = c && rd15; end
            4'd9: begin b = 1; r = 2; pcw = c; end
            default: ;
        endcase
        return {pcw, mwr, rw, irw, adr, {op == 2'b01, op == 2'b10}, a, b, r, op, alu, sh, p};
    endfunction

    task automatic check(input string tag, input logic [22:0] o, input logic [22:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s dut%0d instr=%h observed=%h expected=%h", tag, sel, instr, o, e);
        end
    endtask

    // Entered and left at posedge+1; reset is held for one full cycle.
    task automatic do_reset();
        logic [22:0] e;
        if (sel == 1) rst1 = 1'b0; else rst0 = 1'b0;
        m_flags = '0;
        m_cond  = 1'b0;
        #1;
        e = expv(4'd0, instr, 1'b1, 1'b0, 1'b0, 1'b0);
        e[22:19] = '0;
        e[0 +: 4] = 4'd0;
        e[4] = (sel == 0);
        e[4] = 1'b0;
        check("reset_now", obs, e);
        @(posedge clk); #1;
        check("reset_held", obs, e);
        if (sel == 1) rst1 = 1'b1; else rst0 = 1'b1;
    endtask

    // Runs one instruction; fl[4] forces the ALU flags; abort resets in a MEMREAD stall.
    task automatic run_instr(input logic [19:0] ins, input int unsigned pct,
                             input logic [4:0] fl, input bit abort);
        logic [3:0] path[$];
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] cmd;
        logic [3:0] p;
        logic [3:0] fl_now;
        int unsigned stalls;
        bit mw, mr, can_stall;
        mw = (sel == 1);
        op = ins[15:14]; fn = ins[13:8]; cmd = fn[4:1];
        path.delete();
        path.push_back(4'd0);
        path.push_back(4'd1);
        case (op)
            2'b00: begin path.push_back(fn[5] ? 4'd7 : 4'd6); path.push_back(4'd8); end
            2'b01: begin
                path.push_back(4'd2);
                if (fn[0]) begin path.push_back(4'd3); path.push_back(4'd4); end
                else path.push_back(4'd5);
            end
            2'b10: path.push_back(4'd9);
            default: ;
        endcase
        instr = ins;
        foreach (path[k]) begin
            p = path[k];
            stalls = 0;
            forever begin
                if (abort && p == 4'd3 && stalls == 2) begin
                    do_reset();
                    return;
                end
                mr = ($urandom_range(99) < pct);
                if (abort && p == 4'd3) mr = 1'b0;
                else if (stalls >= 3) mr = 1'b1;
                can_stall = mw && (p == 4'd0 || p == 4'd3 || (p == 4'd5 && m_cond));
                memready = mr;
                aluflags = fl[4] ? fl[3:0] : 4'($urandom);
                fl_now = aluflags;
                #1;
                check($sformatf("step%0d", p), obs,
                      expv(p, ins, mr, m_cond, mw, (sel == 0)));
                @(posedge clk); #1;
                if (p == 4'd1) m_cond = cond_holds(ins[19:16], m_flags);
                if ((p == 4'd6 || p == 4'd7) && fn[0] && m_cond) begin
                    m_flags[3:2] = fl_now[3:2];
                    if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010)
                        m_flags[1:0] = fl_now[1:0];
                end
                if (!(can_stall && !mr)) break;
                stalls++;
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            sel = s;
            @(posedge clk); #1;
            do_reset();
            run_instr(20'hE0821, 100, 5'h00, 1'b0);   // ADD R1,R2,R3
            run_instr(20'hE0521, 100, 5'h14, 1'b0);   // SUBS, Z=1
            run_instr(20'h00821, 100, 5'h00, 1'b0);   // ADDEQ
            run_instr(20'h10821, 100, 5'h00, 1'b0);   // ADDNE
            run_instr(20'hE5921, 0,   5'h00, 1'b0);   // LDR with 3 stall cycles
            run_instr(20'h15821, 0,   5'h00, 1'b0);   // STRNE, Z=1
            run_instr(20'hE5821, 0,   5'h00, 1'b0);   // STR with stalls
            run_instr(20'hE1510, 100, 5'h18, 1'b0);   // CMP R1,R2
            run_instr(20'hEA000, 100, 5'h00, 1'b0);   // B
            run_instr(20'hE1A01, 100, 5'h00, 1'b0);   // MOV
            run_instr(20'hE082F, 100, 5'h00, 1'b0);   // ADD to PC
            run_instr(20'hE592F, 50,  5'h00, 1'b0);   // LDR to PC
            run_instr(20'hE2921, 100, 5'h1F, 1'b0);   // ADDS immediate
            run_instr(20'hFA000, 100, 5'h00, 1'b0);   // never-branch
            run_instr(20'hEC000, 100, 5'h00, 1'b0);   // Op=11
            run_instr(20'hE0521, 100, 5'h14, 1'b0);   // SUBS, Z=1
            run_instr(20'hE5921, 0,   5'h00, 1'b1);   // LDR aborted by reset
            run_instr(20'h00821, 100, 5'h00, 1'b0);   // ADDEQ after flags cleared
            for (int i = 0; i < 150; i++)
                run_instr(20'($urandom), 60, 5'h00, 1'b0);
            if (s == 0) rst0 = 1'b0;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
